// File: rtl/encode_32_5_seq.sv
// encode_32_5_seq: sequential 32-to-5 priority encoder for the FP normalise path.
// A 32-bit word is accepted over valid/ready, then scanned MSB-first one 8-bit
// group per cycle. The result is the index of the most-significant set bit plus
// an all-zero flag, presented over a second valid/ready handshake.
//
// Build option: define ENCODE_EARLY_EXIT_EN to leave the scan on the first
// non-zero group (latency 1..4 scan cycles). Undefined, the scan always visits
// all four groups (fixed latency of 4 scan cycles). Results are identical.
module encode_32_5_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_WIDTH   = 5,
    parameter int GROUP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_index,
    output logic                  out_zero
);

    localparam int NUM_GROUPS = DATA_WIDTH / GROUP_WIDTH;
    localparam int GRP_BITS   = $clog2(NUM_GROUPS);
    localparam int POS_BITS   = $clog2(GROUP_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  data;
    logic [GRP_BITS-1:0]    grp;
    logic                   found;

    logic [GROUP_WIDTH-1:0] group_bits;
    logic                   group_hit;
    logic [POS_BITS-1:0]    group_pos;

    // Position of the highest set bit inside one group; 0 when the group is empty.
    function automatic logic [POS_BITS-1:0] highest_bit(input logic [GROUP_WIDTH-1:0] g);
        logic [POS_BITS-1:0] pos;
        pos = '0;
        for (int i = 0; i < GROUP_WIDTH; i++) begin
            if (g[i]) pos = POS_BITS'(i);
        end
        return pos;
    endfunction

    // Handshake ready: only while idle and out of reset.
    assign in_ready = (state == IDLE) && rst_n;

    // Select the group currently under examination.
    always_comb begin
        // NOTE: default first so every path assigns group_bits and no latch is inferred.
        group_bits = '0;
        case (grp)
            2'd3:    group_bits = data[31:24];
            2'd2:    group_bits = data[23:16];
            2'd1:    group_bits = data[15:8];
            default: group_bits = data[7:0];
        endcase
    end

    assign group_hit = |group_bits;
    assign group_pos = highest_bit(group_bits);

    // Control FSM with registered data path and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the word register is reset along with the control state so an
            // aborted scan leaves nothing behind and idle contents are deterministic.
            state     <= IDLE;
            data      <= '0;
            grp       <= '0;
            found     <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_zero  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read sees the
            // value from before this edge regardless of statement order.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data     <= in_data;
                        grp      <= GRP_BITS'(NUM_GROUPS - 1);
                        found    <= 1'b0;
                        out_zero <= 1'b0;
                        state    <= SCAN;
                    end
                end

                SCAN: begin
                    // First hit wins; later groups never overwrite it.
                    if (group_hit && !found) begin
                        out_index <= {grp, group_pos};
                        out_zero  <= 1'b0;
                        found     <= 1'b1;
                    end
`ifdef ENCODE_EARLY_EXIT_EN
                    if (group_hit) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (grp == '0) begin
`else
                    if (grp == '0) begin
`endif
                        state     <= DONE;
                        out_valid <= 1'b1;
                        if (!found && !group_hit) begin
                            out_zero  <= 1'b1;
                            out_index <= '0;
                        end
                    end else begin
                        grp <= grp - 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
